// File: rtl/rv_g_sb_regfile.sv
// Scoreboarded 64-entry unified X/F register file with per-register outstanding-write counters.
// Latency: combinational read and grant; locks, data and busy_o update on the next clk_i edge.
// Backpressure: gnt_o drops while any needed source or the destination counter is not ready.
// Optional build macro RV_G_SB_REGFILE_NANBOX_EN: F reads fill bits above FLEN with 1s.
module rv_g_sb_regfile #(
  parameter int XLEN             = 64,
  parameter int FLEN             = 64,
  parameter int NUM_WR_PORTS     = 2,
  parameter int NUM_RS           = 3,
  parameter int LOCK_CNT_W       = 2,
  parameter bit ALLOW_FORWARDING = 1'b1,
  localparam int MaxLen          = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  logic [NUM_WR_PORTS-1:0]              wr_en_i,
  input  logic [NUM_WR_PORTS-1:0][5:0]         wr_addr_i,
  input  logic [NUM_WR_PORTS-1:0][MaxLen-1:0]  wr_data_i,
  input  logic                                 req_i,
  input  logic                                 rd_used_i,
  input  logic [5:0]                           rd_addr_i,
  input  logic [NUM_RS-1:0]                    rs_used_i,
  input  logic [NUM_RS-1:0][5:0]               rs_addr_i,
  output logic [NUM_RS-1:0][MaxLen-1:0]        rs_data_o,
  output logic                                 gnt_o,
  input  logic                                 flush_i,
  output logic                                 busy_o
);

  typedef logic [LOCK_CNT_W-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  logic [MaxLen-1:0] regs_q   [64];
  cnt_t              cnt_q    [64];
  cnt_t              cnt_post [64];
  cnt_t              cnt_d    [64];
  logic [63:0]       wr_hit;
  logic [MaxLen-1:0] wr_val   [64];
  logic [NUM_RS-1:0] rs_rdy;
  logic              rd_rdy;
  logic              lock_inc;
  logic              busy_d;

  // Bits that belong to the X bank (is_f=0) or F bank (is_f=1)
  function automatic logic [MaxLen-1:0] bank_mask(input logic is_f);
    logic [MaxLen-1:0] m;
    m = '0;
    for (int b = 0; b < MaxLen; b++) begin
      m[b] = (b < (is_f ? FLEN : XLEN));
    end
    return m;
  endfunction

  // Cut a raw value to its bank width and extend it to MaxLen
  function automatic logic [MaxLen-1:0] bank_view(input logic is_f, input logic [MaxLen-1:0] raw);
    logic [MaxLen-1:0] m;
    logic [MaxLen-1:0] r;
    m = bank_mask(is_f);
    r = raw & m;
`ifdef RV_G_SB_REGFILE_NANBOX_EN
    if (is_f) r = r | ~m;
`endif
    return r;
  endfunction

  // Write decode: highest-index port wins the data; x0 writes are dropped
  always_comb begin
    for (int r = 0; r < 64; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
    end
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en_i[p] && wr_addr_i[p] != 6'd0) begin
        wr_hit[wr_addr_i[p]] = 1'b1;
        wr_val[wr_addr_i[p]] = wr_data_i[p] & bank_mask(wr_addr_i[p][5]);
      end
    end
  end

  // Counters after this cycle's write-back unlocks, saturating at zero
  always_comb begin
    for (int r = 0; r < 64; r++) begin
      cnt_post[r] = cnt_q[r];
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_en_i[p] && wr_addr_i[p] == 6'(r) && cnt_post[r] != '0) begin
          cnt_post[r] = cnt_post[r] - cnt_t'(1);
        end
      end
    end
  end

  // Source read, forwarding of the final outstanding write, and readiness
  always_comb begin
    logic [5:0]        a;
    logic              fwd_hit;
    logic              fwd_ok;
    logic [MaxLen-1:0] fwd_val;
    for (int i = 0; i < NUM_RS; i++) begin
      a       = rs_addr_i[i];
      fwd_hit = 1'b0;
      fwd_val = '0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_en_i[p] && wr_addr_i[p] == a && a != 6'd0) begin
          fwd_hit = 1'b1;
          fwd_val = wr_data_i[p];
        end
      end
      fwd_ok       = ALLOW_FORWARDING && fwd_hit && (cnt_q[a] == cnt_t'(1));
      rs_data_o[i] = bank_view(a[5], fwd_ok ? fwd_val : regs_q[a]);
      rs_rdy[i]    = !rs_used_i[i] || (cnt_q[a] == '0) || fwd_ok;
    end
  end

  // Issue grant: destination counter must have headroom after unlocks
  always_comb begin
    rd_rdy   = !rd_used_i || (rd_addr_i == 6'd0) || (cnt_post[rd_addr_i] != CntMax);
    gnt_o    = req_i && !flush_i && rd_rdy && (&rs_rdy);
    lock_inc = gnt_o && rd_used_i && (rd_addr_i != 6'd0);
  end

  // Next counter values: unlocks, new lock, flush override; busy from the result
  always_comb begin
    busy_d = 1'b0;
    for (int r = 0; r < 64; r++) begin
      cnt_d[r] = cnt_post[r];
      if (lock_inc && rd_addr_i == 6'(r)) cnt_d[r] = cnt_d[r] + cnt_t'(1);
      if (flush_i) cnt_d[r] = '0;
      busy_d = busy_d | (cnt_d[r] != '0);
    end
  end

  // State: register data, lock counters and busy flag
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int r = 0; r < 64; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      busy_o <= 1'b0;
    end else begin
      for (int r = 0; r < 64; r++) begin
        if (wr_hit[r]) regs_q[r] <= wr_val[r];
        cnt_q[r] <= cnt_d[r];
      end
      busy_o <= busy_d;
    end
  end

endmodule
